// File: rtl/alu_pkg.sv
// Shared opcode/error constants, command word and screening helpers
// for the ALU command sequencer.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_FACT = 4'd4;
  localparam logic [3:0] OP_EXP  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_XOR  = 4'd8;
  localparam logic [3:0] OP_NOT  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_DIV0    = 2'd1;
  localparam logic [1:0] ERR_RANGE   = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  localparam logic [15:0] FACT_MAX = 16'd12;
  localparam logic [15:0] EXP_MAX  = 16'd22;

  typedef struct packed {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic logic is_wide(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_FACT) || (op == OP_EXP);
  endfunction

  // The three error conditions are mutually exclusive by opcode.
  function automatic logic [1:0] screen(input cmd_t c);
    logic [1:0] err;
    unique case (1'b1)
      (c.op > OP_SHR):
        err = ERR_ILLEGAL;
      (c.op == OP_DIV && c.b == '0):
        err = ERR_DIV0;
      ((c.op == OP_FACT && c.a > FACT_MAX) ||
       (c.op == OP_EXP && c.a > EXP_MAX)):
        err = ERR_RANGE;
      default:
        err = ERR_NONE;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; count register separates full from empty.
// Reads are combinational from the head slot.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cmd_t           r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [AW:0]    r_cnt;
  logic           w_push;
  logic           w_pop;

  assign full   = (r_cnt == (AW+1)'(DEPTH));
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Screens queued ALU commands, drives legal ones into the ALU and
// returns the captured result with an error code.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [15:0] cmd_a,
  input  logic [15:0] cmd_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_res,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  localparam int CW =
    (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [15:0]   r_alu_a;
  logic [15:0]   r_alu_b;
  logic [3:0]    r_alu_op;
  logic [31:0]   r_rsp_data;
  logic [1:0]    r_rsp_err;
  cmd_t          w_wdata;
  cmd_t          w_head;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [1:0]    w_err;

  assign w_wdata = {cmd_op, cmd_a, cmd_b};

  alu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .wdata (w_wdata),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_err     = screen(w_head);
  assign cmd_ready = !w_full;
  assign busy      = !w_empty || (r_state != ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign rsp_data  = r_rsp_data;
  assign rsp_err   = r_rsp_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = (w_err != ERR_NONE) ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: if (r_cnt == '0) w_next = ST_RESP;
      ST_RESP: if (rsp_ready)   w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Errored commands never touch the ALU operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_op   <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= ERR_NONE;
    end else if (r_state == ST_IDLE && !w_empty) begin
      if (w_err != ERR_NONE) begin
        r_rsp_data <= '0;
        r_rsp_err  <= w_err;
      end else begin
        r_alu_a  <= w_head.a;
        r_alu_b  <= w_head.b;
        r_alu_op <= w_head.op;
        r_cnt    <= CW'(SETTLE_CYCLES - 1);
      end
    end else if (r_state == ST_WAIT) begin
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else begin
        r_rsp_data <= is_wide(r_alu_op) ?
                      alu_res : {16'b0, alu_res[15:0]};
        r_rsp_err  <= ERR_NONE;
      end
    end
  end

endmodule
